// File: rtl/boot_loader_pkg.sv
// Shared types and defaults for the boot loader: state encoding and image-format limits.
package boot_loader_pkg;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_WORDS = 256;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_LOAD   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } bootState_t;

  function automatic logic isBusy(input bootState_t s);
    return (s == ST_HEADER) || (s == ST_LOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Word-source stream plus instruction-memory write port seen by the boot loader.
interface boot_loader_if
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic              mem_cs;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_address, mem_data, mem_we, mem_cs
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_address, mem_data, mem_we, mem_cs
  );

endinterface

// File: rtl/boot_loader_checksum.sv
// Running modulo-2^DATA_W sum of image words with clear/add and an equality compare.
module boot_checksum
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              add,
  input  logic [DATA_W-1:0] addend,
  input  logic [DATA_W-1:0] compareWord,
  output logic              match
);

  logic [DATA_W-1:0] sumQ;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sumQ <= '0;
    end else if (clear) begin
      sumQ <= '0;
    end else if (add) begin
      sumQ <= sumQ + addend;
    end
  end

  assign match = (sumQ == compareWord);

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed program image into instruction memory, then releases the core.
// BOOT_CHECKSUM_EN adds a trailing checksum word checked in CHECK before release.
//
//  state  | meaning
//  IDLE   | waiting for start after reset
//  HEADER | accepting the length word N
//  LOAD   | accepting image words, one memory write per transfer
//  CHECK  | accepting the checksum word (BOOT_CHECKSUM_EN only)
//  DONE   | image in memory, core released once the last write has landed
//  ERROR  | bad length or checksum; start retries from HEADER
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  boot_loader_if.master     bus,
  output logic              cpu_reset,
  output logic              cpu_run,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);

  bootState_t        stateQ, stateD;
  logic [ADDR_W-1:0] lenQ;
  logic [ADDR_W-1:0] countQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] dataQ;
  logic              weQ;
  logic              inReady;
  logic              clearLoad;
  logic              latchLen;
  logic              writeTake;
  logic              lastWord;

  assign lastWord = (countQ == lenQ - ADDR_W'(1));

`ifdef BOOT_CHECKSUM_EN
  logic sumMatch;

  boot_checksum #(.DATA_W(DATA_W)) uChecksum (
    .clock       (clock),
    .reset       (reset),
    .clear       (clearLoad),
    .add         (writeTake),
    .addend      (bus.in_data),
    .compareWord (bus.in_data),
    .match       (sumMatch)
  );
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ <= ST_IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD    = stateQ;
    inReady   = 1'b0;
    clearLoad = 1'b0;
    latchLen  = 1'b0;
    writeTake = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        if (start) begin
          stateD    = ST_HEADER;
          clearLoad = 1'b1;
        end
      end
      ST_HEADER: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          if (bus.in_data == '0) begin
            stateD = ST_DONE;
          end else if (bus.in_data > DATA_W'(MAX_WORDS)) begin
            stateD = ST_ERROR;
          end else begin
            stateD   = ST_LOAD;
            latchLen = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          writeTake = 1'b1;
          if (lastWord) begin
`ifdef BOOT_CHECKSUM_EN
            stateD = ST_CHECK;
`else
            stateD = ST_DONE;
`endif
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CHECK: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          stateD = sumMatch ? ST_DONE : ST_ERROR;
        end
      end
`endif
      ST_DONE: begin
        stateD = ST_DONE;
      end
      ST_ERROR: begin
        if (start) begin
          stateD    = ST_HEADER;
          clearLoad = 1'b1;
        end
      end
      default: begin
        stateD = ST_IDLE;
      end
    endcase
  end

  // Write register: a transfer in LOAD becomes a one-cycle strobe on the next clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lenQ   <= '0;
      countQ <= '0;
      addrQ  <= BASE_ADDR;
      dataQ  <= '0;
      weQ    <= 1'b0;
    end else begin
      weQ <= writeTake;
      if (latchLen) begin
        lenQ <= ADDR_W'(bus.in_data);
      end
      if (clearLoad) begin
        countQ <= '0;
      end else if (writeTake) begin
        countQ <= countQ + ADDR_W'(1);
      end
      if (writeTake) begin
        addrQ <= BASE_ADDR + countQ;
        dataQ <= bus.in_data;
      end
    end
  end

  assign bus.in_ready    = inReady;
  assign bus.mem_we      = weQ;
  assign bus.mem_cs      = ~weQ;
  assign bus.mem_address = addrQ;
  assign bus.mem_data    = dataQ;

  // The core is held until the final write strobe has retired.
  assign cpu_run      = (stateQ == ST_DONE) & ~weQ;
  assign cpu_reset    = ~cpu_run;
  assign busy         = isBusy(stateQ);
  assign error        = (stateQ == ST_ERROR);
  assign words_loaded = countQ;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader with a transaction-level reference model and per-cycle compare.
module tb_boot_loader;
  import boot_loader_pkg::*;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          MAXW = 256;
  localparam logic [31:0] BASE = 32'h0;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cpuReset, cpuRun, busy, error;
  logic [31:0] wordsLoaded;

  boot_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  boot_loader #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_reset    (cpuReset),
    .cpu_run      (cpuRun),
    .busy         (busy),
    .error        (error),
    .words_loaded (wordsLoaded)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int printed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (printed < 40) begin
        printed++;
        $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Reference model: tracks the image as a sequence of accepted words.
  bit          mStarted, mHaveLen, mDone, mErr, mPendWe;
  logic [31:0] mLen, mGot, mSum, mLastAddr, mLastData;
  logic [31:0] expMem[logic [31:0]];
  logic [31:0] memArr[logic [31:0]];

  function automatic void modelReset();
    mStarted  = 0;
    mHaveLen  = 0;
    mDone     = 0;
    mErr      = 0;
    mPendWe   = 0;
    mLen      = 0;
    mGot      = 0;
    mSum      = 0;
    mLastAddr = BASE;
    mLastData = 0;
  endfunction

  function automatic bit expReady();
    return mStarted && !mDone && !mErr;
  endfunction

  function automatic void modelStep();
    bit          pend;
    logic [31:0] d;
    pend = 0;
    d    = bus.in_data;
    if (!mDone && (!mStarted || mErr)) begin
      if (start) begin
        mStarted = 1;
        mErr     = 0;
        mHaveLen = 0;
        mGot     = 0;
        mSum     = 0;
      end
    end else if (expReady() && bus.in_valid) begin
      if (!mHaveLen) begin
        if (d == 0) mDone = 1;
        else if (d > MAXW) mErr = 1;
        else begin
          mHaveLen = 1;
          mLen     = d;
        end
      end else if (mGot < mLen) begin
        pend                = 1;
        mLastAddr           = BASE + mGot;
        mLastData           = d;
        expMem[BASE + mGot] = d;
        mGot                = mGot + 1;
        mSum                = mSum + d;
        if (mGot == mLen && !CK) mDone = 1;
      end else begin
        if (d == mSum) mDone = 1;
        else mErr = 1;
      end
    end
    mPendWe = pend;
  endfunction

  always @(negedge reset) modelReset();

  always @(posedge clock) if (reset) modelStep();

  int cyc = 0;
  always @(posedge clock) cyc++;

  int   weCount = 0;
  int   weAddr[$];
  int   weCyc[$];
  always @(negedge clock) begin
    if (bus.mem_we && !bus.mem_cs) begin
      memArr[bus.mem_address] = bus.mem_data;
      weCount++;
      weAddr.push_back(int'(bus.mem_address));
      weCyc.push_back(cyc);
    end
  end

  bit cmpEn = 0;
  always @(negedge clock) begin
    if (cmpEn) begin
      chk("cyc_in_ready", bus.in_ready, expReady());
      chk("cyc_mem_we", bus.mem_we, mPendWe);
      chk("cyc_mem_cs", bus.mem_cs, !mPendWe);
      chk("cyc_mem_address", bus.mem_address, mLastAddr);
      chk("cyc_mem_data", bus.mem_data, mLastData);
      chk("cyc_cpu_run", cpuRun, mDone && !mPendWe);
      chk("cyc_cpu_reset", cpuReset, !(mDone && !mPendWe));
      chk("cyc_busy", busy, expReady());
      chk("cyc_error", error, mErr);
      chk("cyc_words_loaded", wordsLoaded, mGot);
    end
  end

  logic [31:0] img[$];

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic sendWord(input logic [31:0] w, input int gapPct);
    bit rdy;
    bit ok;
    if (gapPct >= 100) begin
      bus.in_valid = 0;
      bus.in_data  = $urandom();
      tick();
    end else begin
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(99) >= gapPct) break;
        bus.in_valid = 0;
        bus.in_data  = $urandom();
        tick();
      end
    end
    bus.in_valid = 1;
    bus.in_data  = w;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      rdy = bus.in_ready;
      tick();
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    bus.in_valid = 0;
    if (!ok) chk("handshake_timeout", 0, 1);
  endtask

  task automatic sendImage(input int gapPct, input bit goodSum);
    logic [31:0] s;
    s = 0;
    sendWord(img.size(), gapPct);
    foreach (img[i]) begin
      sendWord(img[i], gapPct);
      s = s + img[i];
    end
    if (CK) sendWord(goodSum ? s : s + 1, gapPct);
  endtask

  task automatic pulseStart();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic resetOutputsCheck(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
    chk({tag, "_mem_we"}, bus.mem_we, 1'b0);
    chk({tag, "_mem_cs"}, bus.mem_cs, 1'b1);
    chk({tag, "_cpu_reset"}, cpuReset, 1'b1);
    chk({tag, "_cpu_run"}, cpuRun, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_mem_address"}, bus.mem_address, BASE);
    chk({tag, "_mem_data"}, bus.mem_data, 32'h0);
    chk({tag, "_words_loaded"}, wordsLoaded, 32'h0);
  endtask

  task automatic doReset();
    @(posedge clock);
    #2;
    reset = 0;
    #1;
    resetOutputsCheck("rst");
    tick();
    tick();
    reset = 1;
    weAddr.delete();
    weCyc.delete();
  endtask

  initial begin
    int wc;
    int n;
    bus.in_valid = 0;
    bus.in_data  = 0;
    modelReset();
    #1 reset = 0;
    #2;
    resetOutputsCheck("init");
    cmpEn = 1;
    tick();
    tick();
    reset = 1;

    // Back-to-back image of four words.
    pulseStart();
    img = '{32'h11, 32'h22, 32'h33, 32'h44};
    sendImage(0, 1);
    repeat (3) tick();
    chk("b2b_write_count", weAddr.size(), 4);
    foreach (weAddr[i]) chk("b2b_addr", weAddr[i], i);
    foreach (weCyc[i]) chk("b2b_consecutive", weCyc[i] - weCyc[0], i);
    chk("b2b_mem0", memArr[0], 32'h11);
    chk("b2b_mem3", memArr[3], 32'h44);
    chk("b2b_words_loaded", wordsLoaded, 4);
    chk("b2b_cpu_run", cpuRun, 1'b1);
    chk("b2b_cpu_reset", cpuReset, 1'b0);

    // Same image, valid toggling.
    doReset();
    pulseStart();
    sendImage(100, 1);
    repeat (3) tick();
    chk("tog_write_count", weAddr.size(), 4);
    foreach (weAddr[i]) chk("tog_addr", weAddr[i], i);
    for (int i = 1; i < weCyc.size(); i++) chk("tog_spacing", weCyc[i] - weCyc[i-1], 2);
    chk("tog_words_loaded", wordsLoaded, 4);

    // Reset in the middle of an eight-word load.
    doReset();
    pulseStart();
    img.delete();
    for (int i = 0; i < 8; i++) img.push_back($urandom());
    sendWord(8, 0);
    for (int i = 0; i < 3; i++) sendWord(img[i], 0);
    tick();
    reset = 0;
    #1;
    resetOutputsCheck("midload");
    for (int i = 0; i < 3; i++) chk("midload_mem_kept", memArr[i], img[i]);
    tick();
    tick();
    reset = 1;

    // Oversized header, then a retry.
    pulseStart();
    wc = weCount;
    sendWord(MAXW + 1, 0);
    tick();
    chk("ovr_error", error, 1'b1);
    chk("ovr_cpu_run", cpuRun, 1'b0);
    bus.in_valid = 1;
    bus.in_data  = 32'h5;
    repeat (3) tick();
    bus.in_valid = 0;
    chk("ovr_no_write", weCount, wc);
    pulseStart();
    img = '{32'hDEAD};
    sendImage(0, 1);
    repeat (2) tick();
    chk("retry_cpu_run", cpuRun, 1'b1);
    chk("retry_mem0", memArr[0], 32'hDEAD);

`ifdef BOOT_CHECKSUM_EN
    doReset();
    pulseStart();
    sendWord(3, 0);
    sendWord(1, 0);
    sendWord(2, 0);
    sendWord(3, 0);
    sendWord(6, 0);
    repeat (2) tick();
    chk("ck_good_run", cpuRun, 1'b1);
    doReset();
    pulseStart();
    sendWord(3, 0);
    sendWord(1, 0);
    sendWord(2, 0);
    sendWord(3, 0);
    sendWord(7, 0);
    repeat (2) tick();
    chk("ck_bad_error", error, 1'b1);
    chk("ck_bad_run", cpuRun, 1'b0);
`endif

    // Zero-length image: immediate release, later traffic ignored.
    doReset();
    pulseStart();
    wc = weCount;
    sendWord(0, 0);
    chk("zero_cpu_run", cpuRun, 1'b1);
    start        = 1;
    bus.in_valid = 1;
    repeat (4) begin
      tick();
      chk("zero_in_ready", bus.in_ready, 1'b0);
    end
    start        = 0;
    bus.in_valid = 0;
    chk("zero_no_write", weCount, wc);

    // Randomized images, including one of maximum length and one bad header.
    for (int r = 0; r < 9; r++) begin
      doReset();
      pulseStart();
      if (r == 4) begin
        sendWord($urandom_range(MAXW + 1, 1000), $urandom_range(0, 50));
        repeat ($urandom_range(0, 3)) tick();
        pulseStart();
      end
      n = (r == 8) ? MAXW : $urandom_range(1, 12);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom());
      sendImage((r == 8) ? 0 : $urandom_range(0, 60), ($urandom_range(3) != 0));
      repeat (3) tick();
      start        = 1;
      bus.in_valid = 1;
      bus.in_data  = $urandom();
      repeat (3) tick();
      start        = 0;
      bus.in_valid = 0;
    end

    tick();
    cmpEn = 0;
    chk("mem_size", memArr.size(), expMem.size());
    foreach (expMem[a]) chk("mem_content", memArr.exists(a) ? memArr[a] : 32'hxxxxxxxx, expMem[a]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
